// File: rtl/adc_capture_buffer.sv
// Triggered capture buffer: keeps PRE_TRIG samples of history, freezes a DEPTH window around a rising level crossing, then plays it out.
// Latency: first rd_valid two cycles after entering READ (RAM read + output register), then one sample per cycle.
// Backpressure: rd_valid/rd_ready stream; rd_data/rd_last hold while stalled. Optional ADC_CAPTURE_FORCE_TRIG_EN enables force_trig.
module adc_capture_buffer #(
    parameter int ADC_BITLEN = 16,
    parameter int DEPTH      = 256,
    parameter int PRE_TRIG   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [ADC_BITLEN-1:0] adc_sample,
    input  logic                         adc_valid,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         force_trig,
    input  logic signed [ADC_BITLEN-1:0] trig_level,
    output logic        [ADC_BITLEN-1:0] rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic                         rd_last,
    output logic        [2:0]            state,
    output logic                         done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_PRE_LAST = CW'(PRE_TRIG - 1);
    localparam logic [CW-1:0] C_POST_LAST = CW'(DEPTH - PRE_TRIG - 1);
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_RD_LAST  = CW'(DEPTH - 1);
    localparam logic [AW-1:0] A_ONE      = AW'(1);
    localparam logic [AW-1:0] A_PRE_OFS  = AW'(PRE_TRIG);
    // With PRE_TRIG = DEPTH-1 the trigger sample alone completes the window
    localparam bit            POST_ONE   = (DEPTH - PRE_TRIG) == 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_READ = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_next;

    logic [AW-1:0]                 r_wr_ptr;
    logic [CW-1:0]                 r_cnt;
    logic signed [ADC_BITLEN-1:0]  r_prev;
    logic                          r_prev_vld;
    logic [AW-1:0]                 r_trig_addr;

    logic [ADC_BITLEN-1:0]         r_mem [DEPTH];
    logic [ADC_BITLEN-1:0]         r_ram_q;
    logic                          r_ram_vld;
    logic                          r_ram_last;
    logic [AW-1:0]                 r_rd_addr;
    logic [CW-1:0]                 r_issue_cnt;

    logic [ADC_BITLEN-1:0]         r_rd_data;
    logic                          r_rd_valid;
    logic                          r_rd_last;
    logic                          r_done;

    logic                          w_capturing;
    logic                          w_wr_en;
    logic                          w_start;
    logic                          w_lvl_trig;
    logic                          w_force;
    logic                          w_trig;
    logic                          w_xfer;
    logic                          w_out_free;
    logic                          w_ram_adv;
    logic                          w_ram_free;
    logic                          w_rd_en;
    logic                          w_enter_read;
    logic [AW-1:0]                 w_trig_addr;
    logic [AW-1:0]                 w_rd_start;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_wr_en     = adc_valid && w_capturing && !abort;
    assign w_start     = (r_state == S_IDLE) && arm && !abort;
    assign w_lvl_trig  = r_prev_vld && (r_prev < trig_level) && (adc_sample >= trig_level);
    assign w_trig      = w_lvl_trig || w_force;

`ifdef ADC_CAPTURE_FORCE_TRIG_EN
    logic r_force_pend;

    // A manual trigger request in WAIT is remembered until the next sample fires it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_force_pend <= 1'b0;
        end else if ((r_state != S_WAIT) || (w_next != S_WAIT)) begin
            r_force_pend <= 1'b0;
        end else if (force_trig) begin
            r_force_pend <= 1'b1;
        end
    end

    assign w_force = (r_state == S_WAIT) && (force_trig || r_force_pend);
`else
    logic w_unused_force;
    assign w_unused_force = force_trig;
    assign w_force        = 1'b0;
`endif

    // Read pipeline: RAM stage feeds the output register whenever it is empty or draining
    assign w_xfer       = r_rd_valid && rd_ready;
    assign w_out_free   = !r_rd_valid || rd_ready;
    assign w_ram_adv    = r_ram_vld && w_out_free;
    assign w_ram_free   = !r_ram_vld || w_out_free;
    assign w_rd_en      = (r_state == S_READ) && !abort && (r_issue_cnt != C_DEPTH) && w_ram_free;
    assign w_enter_read = (w_next == S_READ) && (r_state != S_READ);
    // When the trigger itself completes the window, its address is not yet latched
    assign w_trig_addr  = (r_state == S_WAIT) ? r_wr_ptr : r_trig_addr;
    assign w_rd_start   = w_trig_addr - A_PRE_OFS;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (arm) w_next = S_PRE;
            S_PRE:  if (w_wr_en && (r_cnt == C_PRE_LAST)) w_next = S_WAIT;
            S_WAIT: if (w_wr_en && w_trig) w_next = POST_ONE ? S_READ : S_POST;
            S_POST: if (w_wr_en && (r_cnt == C_POST_LAST)) w_next = S_READ;
            S_READ: if (w_xfer && r_rd_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // Capture side: write pointer, sample counts, previous sample and trigger address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_prev      <= '0;
            r_prev_vld  <= 1'b0;
            r_trig_addr <= '0;
        end else if (w_start) begin
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_prev_vld <= 1'b0;
        end else if (w_wr_en) begin
            r_wr_ptr   <= r_wr_ptr + A_ONE;
            r_prev     <= adc_sample;
            r_prev_vld <= 1'b1;
            case (r_state)
                S_PRE:  r_cnt <= (r_cnt == C_PRE_LAST) ? '0 : r_cnt + C_ONE;
                S_WAIT: begin
                    if (w_trig) begin
                        r_cnt       <= C_ONE;
                        r_trig_addr <= r_wr_ptr;
                    end
                end
                S_POST: r_cnt <= r_cnt + C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Window RAM: capture writes, playback reads with a registered output
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= adc_sample;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_addr];
        end
    end

    // Playback side: read address/issue count, RAM-stage valid and the output stream register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr   <= '0;
            r_issue_cnt <= '0;
            r_ram_vld   <= 1'b0;
            r_ram_last  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_last   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_xfer && r_rd_last && !abort;
            if (abort) begin
                r_ram_vld  <= 1'b0;
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end else begin
                if (w_enter_read) begin
                    r_rd_addr   <= w_rd_start;
                    r_issue_cnt <= '0;
                end else if (w_rd_en) begin
                    r_rd_addr   <= r_rd_addr + A_ONE;
                    r_issue_cnt <= r_issue_cnt + C_ONE;
                end
                if (w_rd_en) begin
                    r_ram_vld  <= 1'b1;
                    r_ram_last <= (r_issue_cnt == C_RD_LAST);
                end else if (w_ram_adv) begin
                    r_ram_vld <= 1'b0;
                end
                if (w_ram_adv) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= r_ram_q;
                    r_rd_last  <= r_ram_last;
                end else if (w_xfer) begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                end
            end
        end
    end

    assign state    = r_state;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign done     = r_done;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer with DEPTH=16, PRE_TRIG=4, ADC_BITLEN=8.
// Expected windows come from the sample list: D samples starting P before the first rising crossing after PRE.
// Directed scenarios plus randomized samples, gaps and rd_ready.
module tb_adc_capture_buffer;

    localparam int W = 8;
    localparam int D = 16;
    localparam int P = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] adc_sample = '0;
    logic                adc_valid = 1'b0;
    logic                arm = 1'b0;
    logic                abort = 1'b0;
    logic                force_trig = 1'b0;
    logic signed [W-1:0] trig_level = '0;
    logic [W-1:0]        rd_data;
    logic                rd_valid;
    logic                rd_ready = 1'b0;
    logic                rd_last;
    logic [2:0]          state;
    logic                done;

    int checks   = 0;
    int failures = 0;
    int q_s[$];
    int q_exp[$];

    always #5 clk = ~clk;

    adc_capture_buffer #(.ADC_BITLEN(W), .DEPTH(D), .PRE_TRIG(P)) dut (
        .clk(clk), .rst(rst), .adc_sample(adc_sample), .adc_valid(adc_valid),
        .arm(arm), .abort(abort), .force_trig(force_trig), .trig_level(trig_level),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .state(state), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first rising crossing after the PRE samples, window starts P samples earlier
    function automatic void build_exp(input int lvl);
        int t;
        t = -1;
        q_exp.delete();
        for (int i = P; i < q_s.size(); i++) begin
            if (q_s[i-1] < lvl && q_s[i] >= lvl) begin
                t = i;
                break;
            end
        end
        if (t >= 0) begin
            for (int j = t - P; j < t - P + D && j < q_s.size(); j++) q_exp.push_back(q_s[j]);
        end
    endfunction

    task automatic do_arm(input string tag);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk({tag, "_armed"}, 32'(state), 32'd1);
    endtask

    task automatic feed(input int gap_lo, input int gap_hi, input logic [2:0] stop_st, output bit reached);
        int i;
        int g;
        i = 0;
        while (i < q_s.size() && state != stop_st) begin
            adc_sample = W'(q_s[i]);
            adc_valid  = 1'b1;
            tick();
            adc_valid = 1'b0;
            i++;
            g = int'($urandom_range(gap_hi, gap_lo));
            while (g > 0 && state != stop_st) begin
                tick();
                g--;
            end
        end
        reached = (state == stop_st);
    endtask

    task automatic readout(input int ready_pct, input string tag, output int first_vld, output int cycles);
        int           k;
        int           cyc;
        bit           rdy;
        bit           held;
        logic [W-1:0] hd;
        logic         hl;
        logic [W-1:0] e;
        k = 0; cyc = 0; held = 1'b0; hd = '0; hl = 1'b0;
        first_vld = -1;
        while (k < D && cyc < 1000) begin
            if (held) begin
                chk({tag, "_stall_vld"}, 32'(rd_valid), 32'd1);
                chk({tag, "_stall_data"}, 32'(rd_data), 32'(hd));
                chk({tag, "_stall_last"}, 32'(rd_last), 32'(hl));
            end
            if (rd_valid && first_vld < 0) first_vld = cyc;
            rdy = ($urandom_range(99, 0) < ready_pct);
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                e = W'(q_exp[k]);
                chk({tag, "_data"}, 32'(rd_data), 32'(e));
                chk({tag, "_last"}, 32'(rd_last), 32'(k == D - 1));
                k++;
                held = 1'b0;
            end else begin
                held = rd_valid;
                hd   = rd_data;
                hl   = rd_last;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        cycles = cyc;
        chk({tag, "_count"}, 32'(k), 32'(D));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(state), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run_s1(input string tag);
        bit r;
        int fv;
        int cy;
        trig_level = 8'sd0;
        q_s.delete();
        for (int v = -20; v <= 30; v++) q_s.push_back(v);
        q_exp.delete();
        for (int v = -4; v <= 11; v++) q_exp.push_back(v);
        do_arm(tag);
        feed(2, 2, 3'd4, r);
        chk({tag, "_reach_read"}, 32'(r), 32'd1);
        readout(100, tag, fv, cy);
        chk({tag, "_first_vld"}, 32'(fv), 32'd2);
        chk({tag, "_cycles"}, 32'(cy), 32'd18);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r;
        int fv;
        int cy;
        int lvl;
        int vmax;

        // Reset state
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // abort beats arm in IDLE
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("abort_wins", 32'(state), 32'd0);

        // Scenario 1: ramp, trigger on 0
        run_s1("s1");

        // Scenario 2: crossing during PRE is masked
        trig_level = 8'sd0;
        q_s = '{-1, 0, 0, 0, 0, -3, 5};
        for (int i = 0; i < 11; i++) q_s.push_back(int'($urandom_range(255, 0)) - 128);
        build_exp(0);
        chk("s2_model_len", 32'(q_exp.size()), 32'(D));
        do_arm("s2");
        feed(0, 1, 3'd4, r);
        chk("s2_reach_read", 32'(r), 32'd1);
        readout(100, "s2", fv, cy);

        // Scenario 3: long history wraps the pointer
        q_s.delete();
        for (int v = -50; v <= -11; v++) q_s.push_back(v);
        for (int v = 1; v <= 12; v++) q_s.push_back(v);
        q_exp.delete();
        for (int v = -14; v <= -11; v++) q_exp.push_back(v);
        for (int v = 1; v <= 12; v++) q_exp.push_back(v);
        do_arm("s3");
        feed(0, 2, 3'd4, r);
        chk("s3_reach_read", 32'(r), 32'd1);
        readout(100, "s3", fv, cy);

        // Scenario 4: random samples/level, random rd_ready
        for (int it = 0; it < 3; it++) begin
            lvl = int'($urandom_range(200, 0)) - 100;
            trig_level = W'(lvl);
            q_s.delete();
            for (int i = 0; i < 6 + int'($urandom_range(14, 0)); i++)
                q_s.push_back(int'($urandom_range(255, 0)) - 128);
            q_s.push_back(lvl - 1);
            q_s.push_back(lvl);
            for (int i = 0; i < 12; i++) q_s.push_back(int'($urandom_range(255, 0)) - 128);
            build_exp(lvl);
            chk("s4_model_len", 32'(q_exp.size()), 32'(D));
            do_arm("s4");
            feed(0, 3, 3'd4, r);
            chk("s4_reach_read", 32'(r), 32'd1);
            readout(50, "s4", fv, cy);
        end

        // Scenario 5: manual trigger on a flat input
        trig_level = 8'sd0;
        q_s = '{5, 5, 5, 5};
        do_arm("s5");
        feed(0, 0, 3'd2, r);
        chk("s5_reach_wait", 32'(r), 32'd1);
        force_trig = 1'b1;
        q_s.delete();
        for (int i = 0; i < 30; i++) q_s.push_back(5);
        feed(0, 1, 3'd4, r);
`ifdef ADC_CAPTURE_FORCE_TRIG_EN
        chk("s5_reach_read", 32'(r), 32'd1);
        force_trig = 1'b0;
        q_exp.delete();
        for (int i = 0; i < D; i++) q_exp.push_back(5);
        readout(100, "s5", fv, cy);
`else
        chk("s5_no_read", 32'(r), 32'd0);
        chk("s5_stays_wait", 32'(state), 32'd2);
        force_trig = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s5_abort", 32'(state), 32'd0);
`endif

        // Scenario 6a: abort in POST, no readout follows
        trig_level = 8'sd0;
        q_s.delete();
        for (int v = -20; v <= 30; v++) q_s.push_back(v);
        do_arm("s6");
        feed(0, 1, 3'd3, r);
        chk("s6_reach_post", 32'(r), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s6_abort_idle", 32'(state), 32'd0);
        vmax = 0;
        for (int i = 0; i < 30; i++) begin
            adc_valid  = 1'($urandom_range(1, 0));
            adc_sample = W'(int'($urandom_range(255, 0)) - 128);
            tick();
            if (rd_valid) vmax = 1;
        end
        adc_valid = 1'b0;
        chk("s6_no_rd_valid", 32'(vmax), 32'd0);
        chk("s6_still_idle", 32'(state), 32'd0);

        // Scenario 6b: re-arm completes a full capture
        run_s1("s6_rearm");

        // Scenario 6c: reset during a stalled readout
        q_s.delete();
        for (int v = -20; v <= 30; v++) q_s.push_back(v);
        do_arm("s6r");
        feed(0, 0, 3'd4, r);
        chk("s6r_reach_read", 32'(r), 32'd1);
        rd_ready = 1'b0;
        for (int i = 0; i < 10 && !rd_valid; i++) tick();
        chk("s6r_stalled_vld", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("s6r_state", 32'(state), 32'd0);
        chk("s6r_rd_valid", 32'(rd_valid), 32'd0);
        chk("s6r_rd_data", 32'(rd_data), 32'd0);
        chk("s6r_rd_last", 32'(rd_last), 32'd0);
        chk("s6r_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("s6r_post_rst", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
